// File: rtl/cache_buffer_pkg.sv
// Shared definitions for the cache/external-memory block-transfer buffer:
// address geometry, counter width, direction codes and the controller state set.
package cache_buffer_pkg;

    localparam int BW_WORD_ADDR    = 24;
    localparam int BW_BLOCK        = 4;
    localparam int BLOCK_WORDS_DEF = 1 << BW_BLOCK;
    localparam int BW_CNT          = $clog2(BLOCK_WORDS_DEF) + 1;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_GATHER = 3'd1,
        ST_WR_ISSUE  = 3'd2,
        ST_RD_ISSUE  = 3'd3,
        ST_RD_FILL   = 3'd4,
        ST_RD_DRAIN  = 3'd5
    } state_e;

endpackage

// File: rtl/cache_buffer_ram.sv
// Block-sized word store: one synchronous write port fed by either the cache
// (gather) or external memory (fill), one asynchronous read port.
module cache_buffer_ram
    import cache_buffer_pkg::*;
#(
    parameter  int BLOCK_WORDS = BLOCK_WORDS_DEF,
    localparam int AW          = $clog2(BLOCK_WORDS)
) (
    input  logic          clock_i,
    input  logic          we_i,
    input  logic          gather_sel_i,
    input  logic [AW-1:0] widx_i,
    input  logic [31:0]   wdata_gather_i,
    input  logic [31:0]   wdata_fill_i,
    input  logic          drain_sel_i,
    input  logic [AW-1:0] ridx_issue_i,
    input  logic [AW-1:0] ridx_drain_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [BLOCK_WORDS];
    logic [31:0] wdata_s;
    logic [AW-1:0] ridx_s;

    assign wdata_s = gather_sel_i ? wdata_gather_i : wdata_fill_i;
    assign ridx_s  = drain_sel_i ? ridx_drain_i : ridx_issue_i;
    assign rdata_o = mem_q[ridx_s];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem_q[widx_i] <= wdata_s;
        end
    end

endmodule

// File: rtl/cache_mem_buffer.sv
// Single-command buffer between the cache controller and external memory:
// gathers or fills one word/block and sequences the external beats.
module cache_mem_buffer
    import cache_buffer_pkg::*;
#(
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
    input  logic                    clock_i,
    input  logic                    resetn_i,
    input  logic                    req_i,
    input  logic                    req_block_i,
    input  logic                    rw_i,
    input  logic [BW_WORD_ADDR-1:0] add_i,
    input  logic                    write_i,
    input  logic [31:0]             data_i,
    input  logic                    read_i,
    output logic                    ready_req_o,
    output logic                    ready_write_o,
    output logic                    ready_read_o,
    output logic [31:0]             data_o,
    output logic                    ext_req_o,
    output logic                    ext_rw_o,
    output logic                    ext_burst_o,
    output logic [BW_WORD_ADDR-1:0] ext_add_o,
    output logic [31:0]             ext_data_o,
    input  logic                    ext_ack_i,
    input  logic                    ext_valid_i,
    input  logic [31:0]             ext_data_i
);

    localparam int AW = $clog2(BLOCK_WORDS);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]           LEN_BLOCK  = CW'(BLOCK_WORDS);
    localparam logic [CW-1:0]           LEN_WORD   = CW'(1);
    localparam logic [BW_WORD_ADDR-1:0] ALIGN_MASK = BW_WORD_ADDR'(BLOCK_WORDS - 1);

    state_e                  state_q, state_d;
    logic [CW-1:0]           wcnt_q, wcnt_d;
    logic [CW-1:0]           rcnt_q, rcnt_d;
    logic [CW-1:0]           len_q, len_d;
    logic [BW_WORD_ADDR-1:0] base_q, base_d;
    logic                    dir_q, dir_d;
    logic                    block_q, block_d;
    logic                    ram_we_s;
    logic [31:0]             ram_rdata_s;

    // State and command registers; reset aborts any transfer in flight.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            len_q   <= '0;
            base_q  <= '0;
            dir_q   <= DIR_READ;
            block_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            len_q   <= len_d;
            base_q  <= base_d;
            dir_q   <= dir_d;
            block_q <= block_d;
        end
    end

    // Next-state logic; strobes not meaningful in the current state fall through unused.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        len_d   = len_q;
        base_d  = base_q;
        dir_d   = dir_q;
        block_d = block_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    base_d  = req_block_i ? (add_i & ~ALIGN_MASK) : add_i;
                    len_d   = req_block_i ? LEN_BLOCK : LEN_WORD;
                    dir_d   = rw_i;
                    block_d = req_block_i;
                    wcnt_d  = '0;
                    rcnt_d  = '0;
                    state_d = (rw_i == DIR_WRITE) ? ST_WR_GATHER : ST_RD_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_GATHER: begin
                if (write_i) begin
                    if (wcnt_q == len_q - CW'(1)) begin
                        wcnt_d  = '0;
                        state_d = ST_WR_ISSUE;
                    end else begin
                        wcnt_d = wcnt_q + CW'(1);
                    end
                end else begin
                    state_d = ST_WR_GATHER;
                end
            end
            ST_WR_ISSUE: begin
                if (ext_ack_i) begin
                    if (wcnt_q == len_q - CW'(1)) begin
                        wcnt_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        wcnt_d = wcnt_q + CW'(1);
                    end
                end else begin
                    state_d = ST_WR_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                if (ext_ack_i) begin
                    state_d = ST_RD_FILL;
                end else begin
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_RD_FILL: begin
                if (ext_valid_i) begin
                    if (wcnt_q == len_q - CW'(1)) begin
                        wcnt_d  = '0;
                        rcnt_d  = '0;
                        state_d = ST_RD_DRAIN;
                    end else begin
                        wcnt_d = wcnt_q + CW'(1);
                    end
                end else begin
                    state_d = ST_RD_FILL;
                end
            end
            ST_RD_DRAIN: begin
                if (read_i) begin
                    if (rcnt_q == len_q - CW'(1)) begin
                        rcnt_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        rcnt_d = rcnt_q + CW'(1);
                    end
                end else begin
                    state_d = ST_RD_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                wcnt_d  = '0;
                rcnt_d  = '0;
            end
        endcase
    end

    assign ram_we_s = ((state_q == ST_WR_GATHER) && write_i) ||
                      ((state_q == ST_RD_FILL) && ext_valid_i);

    cache_buffer_ram #(
        .BLOCK_WORDS (BLOCK_WORDS)
    ) u_ram (
        .clock_i        (clock_i),
        .we_i           (ram_we_s),
        .gather_sel_i   (state_q == ST_WR_GATHER),
        .widx_i         (wcnt_q[AW-1:0]),
        .wdata_gather_i (data_i),
        .wdata_fill_i   (ext_data_i),
        .drain_sel_i    (state_q == ST_RD_DRAIN),
        .ridx_issue_i   (wcnt_q[AW-1:0]),
        .ridx_drain_i   (rcnt_q[AW-1:0]),
        .rdata_o        (ram_rdata_s)
    );

    // Every output is a pure decode of registered state, zeroed outside its owning state.
    assign ready_req_o   = (state_q == ST_IDLE);
    assign ready_write_o = (state_q == ST_WR_GATHER);
    assign ready_read_o  = (state_q == ST_RD_DRAIN);
    assign ext_req_o     = (state_q == ST_WR_ISSUE) || (state_q == ST_RD_ISSUE);
    assign ext_rw_o      = (state_q == ST_WR_ISSUE) && (dir_q == DIR_WRITE);
    assign ext_burst_o   = (state_q == ST_RD_ISSUE) && block_q;
    assign ext_add_o     = (state_q == ST_WR_ISSUE) ? (base_q + BW_WORD_ADDR'(wcnt_q)) :
                           (state_q == ST_RD_ISSUE) ? base_q : '0;
    assign ext_data_o    = (state_q == ST_WR_ISSUE) ? ram_rdata_s : 32'd0;
    assign data_o        = (state_q == ST_RD_DRAIN) ? ram_rdata_s : 32'd0;

endmodule

// File: tb/tb_cache_mem_buffer.sv
// Directed-plus-random bench for cache_mem_buffer, checked against a
// transaction-level expectation of addresses, beats and popped data.
module tb_cache_mem_buffer;

    logic        clock_i = 1'b0;
    logic        resetn_i;
    logic        req_i, req_block_i, rw_i, write_i, read_i;
    logic [23:0] add_i;
    logic [31:0] data_i;
    logic        ready_req_o, ready_write_o, ready_read_o;
    logic [31:0] data_o;
    logic        ext_req_o, ext_rw_o, ext_burst_o;
    logic [23:0] ext_add_o;
    logic [31:0] ext_data_o;
    logic        ext_ack_i, ext_valid_i;
    logic [31:0] ext_data_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] pat [16];

    cache_mem_buffer #(.BLOCK_WORDS(16)) dut (
        .clock_i(clock_i), .resetn_i(resetn_i), .req_i(req_i), .req_block_i(req_block_i),
        .rw_i(rw_i), .add_i(add_i), .write_i(write_i), .data_i(data_i), .read_i(read_i),
        .ready_req_o(ready_req_o), .ready_write_o(ready_write_o), .ready_read_o(ready_read_o),
        .data_o(data_o), .ext_req_o(ext_req_o), .ext_rw_o(ext_rw_o), .ext_burst_o(ext_burst_o),
        .ext_add_o(ext_add_o), .ext_data_o(ext_data_o), .ext_ack_i(ext_ack_i),
        .ext_valid_i(ext_valid_i), .ext_data_i(ext_data_i)
    );

    always #5 clock_i = ~clock_i;

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned exp_base(input int unsigned addr, input bit block);
        return block ? (addr - (addr % 16)) : addr;
    endfunction

    task automatic do_read(input int unsigned addr, input bit block);
        int n = block ? 16 : 1;
        int unsigned base = exp_base(addr, block);
        chk("rd_ready_req", {31'd0, ready_req_o}, 32'd1);
        req_i = 1'b1; req_block_i = block; rw_i = 1'b0; add_i = addr[23:0];
        tick();
        req_i = 1'b0; add_i = $urandom;
        chk("rd_ext_req", {31'd0, ext_req_o}, 32'd1);
        chk("rd_ext_rw", {31'd0, ext_rw_o}, 32'd0);
        chk("rd_ext_burst", {31'd0, ext_burst_o}, {31'd0, block});
        chk("rd_ext_add", {8'd0, ext_add_o}, base);
        repeat ($urandom_range(0, 2)) begin
            req_i = 1'b1;
            tick();
            chk("rd_issue_hold", {8'd0, ext_add_o}, base);
        end
        req_i = 1'b0;
        ext_ack_i = 1'b1;
        tick();
        ext_ack_i = 1'b0;
        chk("rd_fill_no_req", {31'd0, ext_req_o}, 32'd0);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 1)) begin
                read_i = 1'b1; ext_ack_i = 1'b1;
                tick();
                read_i = 1'b0; ext_ack_i = 1'b0;
                chk("rd_fill_not_ready", {31'd0, ready_read_o}, 32'd0);
            end
            ext_valid_i = 1'b1; ext_data_i = pat[i];
            tick();
            ext_valid_i = 1'b0; ext_data_i = $urandom;
        end
        chk("rd_ready_read", {31'd0, ready_read_o}, 32'd1);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                read_i = 1'b0;
                ext_valid_i = 1'b1;
                tick();
                ext_valid_i = 1'b0;
            end
            chk("rd_data", data_o, pat[i]);
            read_i = 1'b1;
            tick();
        end
        read_i = 1'b0;
        chk("rd_done_ready_req", {31'd0, ready_req_o}, 32'd1);
        chk("rd_done_ready_read", {31'd0, ready_read_o}, 32'd0);
        chk("rd_done_data0", data_o, 32'd0);
    endtask

    task automatic do_write(input int unsigned addr, input bit block, input int stall_at);
        int n = block ? 16 : 1;
        int unsigned base = exp_base(addr, block);
        int unsigned ea;
        chk("wr_ready_req", {31'd0, ready_req_o}, 32'd1);
        req_i = 1'b1; req_block_i = block; rw_i = 1'b1; add_i = addr[23:0];
        write_i = 1'b1; data_i = 32'hBAD0BAD0;
        tick();
        req_i = 1'b0; write_i = 1'b0;
        chk("wr_ready_write", {31'd0, ready_write_o}, 32'd1);
        chk("wr_gather_no_req", {31'd0, ext_req_o}, 32'd0);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 1)) begin
                ext_valid_i = 1'b1; ext_ack_i = 1'b1; data_i = $urandom;
                tick();
                ext_valid_i = 1'b0; ext_ack_i = 1'b0;
            end
            write_i = 1'b1; data_i = pat[i];
            tick();
            write_i = 1'b0; data_i = $urandom;
        end
        chk("wr_gather_done", {31'd0, ready_write_o}, 32'd0);
        for (int i = 0; i < n; i++) begin
            int stall = (i == stall_at) ? 3 : $urandom_range(0, 1);
            ea = (base + i) & 32'h00FF_FFFF;
            chk("wr_ext_req", {31'd0, ext_req_o}, 32'd1);
            chk("wr_ext_rw", {31'd0, ext_rw_o}, 32'd1);
            chk("wr_ext_add", {8'd0, ext_add_o}, ea);
            chk("wr_ext_data", ext_data_o, pat[i]);
            repeat (stall) begin
                req_i = 1'b1; write_i = 1'b1; read_i = 1'b1;
                tick();
                req_i = 1'b0; write_i = 1'b0; read_i = 1'b0;
                chk("wr_stall_add", {8'd0, ext_add_o}, ea);
                chk("wr_stall_data", ext_data_o, pat[i]);
            end
            ext_ack_i = 1'b1;
            tick();
            ext_ack_i = 1'b0;
        end
        chk("wr_done_ready_req", {31'd0, ready_req_o}, 32'd1);
        chk("wr_done_no_req", {31'd0, ext_req_o}, 32'd0);
    endtask

    initial begin
        resetn_i = 1'b0;
        req_i = 1'b0; req_block_i = 1'b0; rw_i = 1'b0; add_i = 24'd0;
        write_i = 1'b0; data_i = 32'd0; read_i = 1'b0;
        ext_ack_i = 1'b0; ext_valid_i = 1'b0; ext_data_i = 32'd0;
        repeat (2) tick();
        chk("rst_ready_req", {31'd0, ready_req_o}, 32'd1);
        chk("rst_ready_write", {31'd0, ready_write_o}, 32'd0);
        chk("rst_ready_read", {31'd0, ready_read_o}, 32'd0);
        chk("rst_ext_req", {31'd0, ext_req_o}, 32'd0);
        chk("rst_ext_add", {8'd0, ext_add_o}, 32'd0);
        chk("rst_ext_data", ext_data_o, 32'd0);
        chk("rst_data", data_o, 32'd0);
        resetn_i = 1'b1;
        tick();

        write_i = 1'b1; ext_valid_i = 1'b1; read_i = 1'b1; ext_ack_i = 1'b1; data_i = 32'h1234_5678;
        tick();
        write_i = 1'b0; ext_valid_i = 1'b0; read_i = 1'b0; ext_ack_i = 1'b0;
        chk("idle_strobe_ready_req", {31'd0, ready_req_o}, 32'd1);
        chk("idle_strobe_ready_write", {31'd0, ready_write_o}, 32'd0);
        chk("idle_strobe_ready_read", {31'd0, ready_read_o}, 32'd0);

        for (int i = 0; i < 16; i++) pat[i] = 32'hA0 + i;
        do_read(32'h00123, 1'b1);
        for (int i = 0; i < 16; i++) pat[i] = 32'h10 + i;
        do_write(32'h00045, 1'b1, 5);
        pat[0] = 32'hDEADBEEF;
        do_read(32'h00007, 1'b0);

        for (int t = 0; t < 8; t++) begin
            int unsigned a = $urandom_range(0, 32'h00FF_FFFF);
            bit blk = 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) pat[i] = $urandom;
            if ($urandom_range(0, 1) == 1) do_write(a, blk, -1);
            else do_read(a, blk);
        end

        for (int i = 0; i < 16; i++) pat[i] = $urandom;
        do_read(32'hFFFFF5, 1'b1);
        do_write(32'hFFFFF5, 1'b1, -1);

        req_i = 1'b1; req_block_i = 1'b1; rw_i = 1'b0; add_i = 24'h000300;
        tick();
        req_i = 1'b0;
        ext_ack_i = 1'b1;
        tick();
        ext_ack_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ext_valid_i = 1'b1; ext_data_i = $urandom;
            tick();
        end
        ext_valid_i = 1'b0;
        #2 resetn_i = 1'b0;
        #1;
        chk("async_rst_ready_req", {31'd0, ready_req_o}, 32'd1);
        chk("async_rst_ready_read", {31'd0, ready_read_o}, 32'd0);
        chk("async_rst_ext_req", {31'd0, ext_req_o}, 32'd0);
        chk("async_rst_data", data_o, 32'd0);
        tick();
        #2 resetn_i = 1'b1;
        tick();
        pat[0] = 32'hC0FFEE01;
        do_read(32'h0000AB, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
